// File: rtl/alu_shift_seq_if.sv
// Bus between the control unit / ALU side and the shift sequencer.
// Parameter: CNT_W - width of the shift-amount field.
// Modports:
//   master - control unit + ALU: drives request fields and ALU results,
//            observes status, result and ALU command fields.
//   slave  - the sequencer (alu_shift_seq).
// Signals:
//   start, dir, fill, rot, amount, op_hi, op_lo       request
//   busy, done, res_hi, res_lo, carry_out              status / result
//   alu_cmd, alu_typeselect, alu_inA, alu_inB,
//   alu_immed, alu_sc_in                               ALU command drive
//   alu_rslt, alu_sc_o                                 ALU response
interface alu_shift_seq_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             dir;
  logic             fill;
  logic             rot;
  logic [CNT_W-1:0] amount;
  logic [7:0]       op_hi;
  logic [7:0]       op_lo;
  logic             busy;
  logic             done;
  logic [7:0]       res_hi;
  logic [7:0]       res_lo;
  logic             carry_out;
  logic [2:0]       alu_cmd;
  logic [2:0]       alu_typeselect;
  logic [7:0]       alu_inA;
  logic [7:0]       alu_inB;
  logic [3:0]       alu_immed;
  logic             alu_sc_in;
  logic [7:0]       alu_rslt;
  logic             alu_sc_o;

  modport master (
    output start, dir, fill, rot, amount, op_hi, op_lo, alu_rslt, alu_sc_o,
    input  busy, done, res_hi, res_lo, carry_out,
    input  alu_cmd, alu_typeselect, alu_inA, alu_inB, alu_immed, alu_sc_in
  );

  modport slave (
    input  start, dir, fill, rot, amount, op_hi, op_lo, alu_rslt, alu_sc_o,
    output busy, done, res_hi, res_lo, carry_out,
    output alu_cmd, alu_typeselect, alu_inA, alu_inB, alu_immed, alu_sc_in
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Multi-cycle 16-bit logical shifter built on the 8-bit ALU shift path.
// Each bit position takes two ALU passes (one per byte) with the ALU
// shift-carry held between them. Shifts of 0 to 2^CNT_W-1 positions.
// Optional feature macro: SHIFT_ROTATE_EN - when defined, a captured rot=1
// turns the operation into a 16-bit rotate.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - alu_shift_seq_if.slave: request, status/result, ALU drive
// All bus outputs are registered. ALU drive for the next cycle is derived
// from the next-state values so the ALU sees its command in the same cycle
// the sequencer samples alu_rslt/alu_sc_o.
module alu_shift_seq #(
  parameter int unsigned CNT_W = 4
) (
  input logic           clk,
  input logic           reset,
  alu_shift_seq_if.slave bus
);

  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] CMD_SHIFT = 3'b001;
  localparam logic [2:0] CMD_NOP   = 3'b111;
  localparam logic [2:0] TS_HI_CARRY_L = 3'b100;
  localparam logic [2:0] TS_LO_CARRY_R = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [BYTE_W-1:0] res_hi_q, res_hi_d;
  logic [BYTE_W-1:0] res_lo_q, res_lo_d;
  logic              carry_q, carry_d;
  logic              carry_out_q, carry_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              fill_q, fill_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        alu_cmd_q, alu_cmd_d;
  logic [2:0]        alu_ts_q, alu_ts_d;
  logic [BYTE_W-1:0] alu_ina_q, alu_ina_d;
  logic              alu_sc_in_q, alu_sc_in_d;

  logic              rot_eff;
  logic              ins_bit;

`ifdef SHIFT_ROTATE_EN
  logic rot_q, rot_d;
  assign rot_eff = rot_d;
`else
  // rot is kept on the interface for a stable port list but has no effect.
  logic unused_rot;
  assign unused_rot = bus.rot;
  assign rot_eff    = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      fill_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alu_cmd_q   <= CMD_NOP;
      alu_ts_q    <= '0;
      alu_ina_q   <= '0;
      alu_sc_in_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      fill_q      <= fill_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_ts_q    <= alu_ts_d;
      alu_ina_q   <= alu_ina_d;
      alu_sc_in_q <= alu_sc_in_d;
`ifdef SHIFT_ROTATE_EN
      rot_q       <= rot_d;
`endif
    end
  end

  // Next-state, datapath update and next-cycle ALU drive.
  always_comb begin
    state_d     = state_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    fill_d      = fill_q;
`ifdef SHIFT_ROTATE_EN
    rot_d       = rot_q;
`endif
    busy_d      = 1'b0;
    done_d      = 1'b0;
    alu_cmd_d   = CMD_NOP;
    alu_ts_d    = '0;
    alu_ina_d   = '0;
    alu_sc_in_d = 1'b0;
    ins_bit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          res_hi_d    = bus.op_hi;
          res_lo_d    = bus.op_lo;
          dir_d       = bus.dir;
          fill_d      = bus.fill;
`ifdef SHIFT_ROTATE_EN
          rot_d       = bus.rot;
`endif
          cnt_d       = bus.amount;
          carry_d     = 1'b0;
          carry_out_d = 1'b0;
          state_d     = (bus.amount == '0) ? DONE : PASS1;
        end
      end
      PASS1: begin
        // Left shifts start at the low byte, right shifts at the high byte.
        if (dir_q) res_hi_d = bus.alu_rslt;
        else       res_lo_d = bus.alu_rslt;
        carry_d = bus.alu_sc_o;
        state_d = PASS2;
      end
      PASS2: begin
        if (dir_q) res_lo_d = bus.alu_rslt;
        else       res_hi_d = bus.alu_rslt;
        carry_d     = bus.alu_sc_o;
        carry_out_d = bus.alu_sc_o;
        cnt_d       = cnt_q - CNT_W'(1);
        state_d     = (cnt_q == CNT_W'(1)) ? DONE : PASS1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    // ALU drive is computed from next-cycle register values so it is valid
    // throughout the pass in which the ALU result is sampled.
    if (state_d == PASS1) begin
      // Rotate inserts the bit about to leave the opposite end of the word.
      ins_bit   = rot_eff ? (dir_d ? res_lo_d[0] : res_hi_d[BYTE_W-1]) : fill_d;
      alu_cmd_d = CMD_SHIFT;
      alu_ts_d  = {1'b0, dir_d, ins_bit};
      alu_ina_d = dir_d ? res_hi_d : res_lo_d;
    end else if (state_d == PASS2) begin
      alu_cmd_d   = CMD_SHIFT;
      alu_ts_d    = dir_d ? TS_LO_CARRY_R : TS_HI_CARRY_L;
      alu_ina_d   = dir_d ? res_lo_d : res_hi_d;
      alu_sc_in_d = carry_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.res_hi         = res_hi_q;
  assign bus.res_lo         = res_lo_q;
  assign bus.carry_out      = carry_out_q;
  assign bus.alu_cmd        = alu_cmd_q;
  assign bus.alu_typeselect = alu_ts_q;
  assign bus.alu_inA        = alu_ina_q;
  assign bus.alu_sc_in      = alu_sc_in_q;
  assign bus.alu_inB        = '0;
  assign bus.alu_immed      = '0;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed self-checking bench for alu_shift_seq with a behavioural
// combinational model of the ALU shift path.
module tb_alu_shift_seq;

  logic clk = 1'b0;
  logic reset;

  alu_shift_seq_if #(.CNT_W(4)) bus_if ();

  alu_shift_seq #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // ALU shift path: 000/001 left fill 0/1, 010/011 right fill 0/1,
  // 100 left with sc_in, 101 right with sc_in. sc_o is the bit shifted out.
  always_comb begin
    bus_if.alu_rslt = 8'h00;
    bus_if.alu_sc_o = 1'b0;
    if (bus_if.alu_cmd == 3'b001) begin
      case (bus_if.alu_typeselect)
        3'b000: {bus_if.alu_sc_o, bus_if.alu_rslt} = {bus_if.alu_inA, 1'b0};
        3'b001: {bus_if.alu_sc_o, bus_if.alu_rslt} = {bus_if.alu_inA, 1'b1};
        3'b010: {bus_if.alu_rslt, bus_if.alu_sc_o} = {1'b0, bus_if.alu_inA};
        3'b011: {bus_if.alu_rslt, bus_if.alu_sc_o} = {1'b1, bus_if.alu_inA};
        3'b100: {bus_if.alu_sc_o, bus_if.alu_rslt} = {bus_if.alu_inA, bus_if.alu_sc_in};
        3'b101: {bus_if.alu_rslt, bus_if.alu_sc_o} = {bus_if.alu_sc_in, bus_if.alu_inA};
        default: begin
          bus_if.alu_rslt = 8'h00;
          bus_if.alu_sc_o = 1'b0;
        end
      endcase
    end
  end

  int errors = 0;
  int checks = 0;
  logic [2:0] ts_log [0:63];
  int n_ts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done, then check latency,
  // result, carry and that done lasts exactly one cycle.
  task automatic run_op(input string tag, input logic d, input logic f, input logic r,
                        input logic [3:0] n, input logic [15:0] op,
                        input logic [15:0] exp_res, input logic exp_c);
    int  cyc;
    bit  seen;
    bus_if.dir    = d;
    bus_if.fill   = f;
    bus_if.rot    = r;
    bus_if.amount = n;
    bus_if.op_hi  = op[15:8];
    bus_if.op_lo  = op[7:0];
    bus_if.start  = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    n_ts = 0;
    while (!seen && cyc < 64) begin
      if (bus_if.done) begin
        seen = 1'b1;
      end else begin
        if (bus_if.alu_cmd == 3'b001) begin
          ts_log[n_ts] = bus_if.alu_typeselect;
          n_ts++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'(1));
    check({tag, " latency"}, 32'(cyc), 32'(1 + 2 * int'(n)));
    check({tag, " res"}, 32'({bus_if.res_hi, bus_if.res_lo}), 32'(exp_res));
    check({tag, " carry_out"}, 32'(bus_if.carry_out), 32'(exp_c));
    check({tag, " busy_at_done"}, 32'(bus_if.busy), 32'(1));
    check({tag, " cmd_at_done"}, 32'(bus_if.alu_cmd), 32'(3'b111));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(bus_if.done), 32'(0));
    check({tag, " idle_after"}, 32'(bus_if.busy), 32'(0));
    check({tag, " res_hold"}, 32'({bus_if.res_hi, bus_if.res_lo}), 32'(exp_res));
  endtask

  initial begin
    int pulses;
    reset         = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.dir    = 1'b0;
    bus_if.fill   = 1'b0;
    bus_if.rot    = 1'b0;
    bus_if.amount = 4'd0;
    bus_if.op_hi  = 8'h00;
    bus_if.op_lo  = 8'h00;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(bus_if.busy), 32'(0));
    check("rst done", 32'(bus_if.done), 32'(0));
    check("rst res", 32'({bus_if.res_hi, bus_if.res_lo}), 32'(16'h0000));
    check("rst carry_out", 32'(bus_if.carry_out), 32'(0));
    check("rst alu_cmd", 32'(bus_if.alu_cmd), 32'(3'b111));
    check("rst alu_inA", 32'(bus_if.alu_inA), 32'(0));
    check("rst alu_inB", 32'(bus_if.alu_inB), 32'(0));
    check("rst alu_immed", 32'(bus_if.alu_immed), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // 2: left by 1, fill 0
    run_op("shl1", 1'b0, 1'b0, 1'b0, 4'd1, 16'h80FF, 16'h01FE, 1'b1);
    check("shl1 n_passes", 32'(n_ts), 32'(2));
    check("shl1 ts0", 32'(ts_log[0]), 32'(3'b000));
    check("shl1 ts1", 32'(ts_log[1]), 32'(3'b100));

    // 3: right by 4, fill 1
    run_op("shr4", 1'b1, 1'b1, 1'b0, 4'd4, 16'h1234, 16'hF123, 1'b0);
    check("shr4 n_passes", 32'(n_ts), 32'(8));
    check("shr4 ts0", 32'(ts_log[0]), 32'(3'b011));
    check("shr4 ts1", 32'(ts_log[1]), 32'(3'b101));

    // 4: amount 0 passes operand through, ALU never commanded
    run_op("amt0", 1'b0, 1'b1, 1'b0, 4'd0, 16'hABCD, 16'hABCD, 1'b0);
    check("amt0 n_passes", 32'(n_ts), 32'(0));

    // Boundary: maximum amount in both directions
    run_op("shl15", 1'b0, 1'b0, 1'b0, 4'd15, 16'h0001, 16'h8000, 1'b0);
    run_op("shr15", 1'b1, 1'b1, 1'b0, 4'd15, 16'h8000, 16'hFFFF, 1'b0);

    // 5a: start pulsed during PASS2 of an amount=3 shift is ignored
    bus_if.dir    = 1'b0;
    bus_if.fill   = 1'b0;
    bus_if.rot    = 1'b0;
    bus_if.amount = 4'd3;
    bus_if.op_hi  = 8'h00;
    bus_if.op_lo  = 8'h01;
    bus_if.start  = 1'b1;
    @(posedge clk); #1;                 // PASS1
    bus_if.start = 1'b0;
    check("ign pass1_type", 32'(bus_if.alu_typeselect), 32'(3'b000));
    @(posedge clk); #1;                 // PASS2
    check("ign pass2_type", 32'(bus_if.alu_typeselect), 32'(3'b100));
    bus_if.op_lo = 8'h55;
    bus_if.start = 1'b1;
    pulses = 0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus_if.done) pulses++;
      @(posedge clk); #1;
    end
    check("ign done_pulses", 32'(pulses), 32'(1));
    check("ign busy_after", 32'(bus_if.busy), 32'(0));
    check("ign res", 32'({bus_if.res_hi, bus_if.res_lo}), 32'(16'h0008));
    check("ign carry_out", 32'(bus_if.carry_out), 32'(0));

    // 5b: reset during PASS1 of an amount=3 shift
    bus_if.dir    = 1'b1;
    bus_if.fill   = 1'b1;
    bus_if.amount = 4'd3;
    bus_if.op_hi  = 8'hF0;
    bus_if.op_lo  = 8'h0F;
    bus_if.start  = 1'b1;
    @(posedge clk); #1;                 // PASS1
    bus_if.start = 1'b0;
    check("rmid busy_pass1", 32'(bus_if.busy), 32'(1));
    check("rmid cmd_pass1", 32'(bus_if.alu_cmd), 32'(3'b001));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rmid busy", 32'(bus_if.busy), 32'(0));
    check("rmid done", 32'(bus_if.done), 32'(0));
    check("rmid res", 32'({bus_if.res_hi, bus_if.res_lo}), 32'(16'h0000));
    check("rmid carry_out", 32'(bus_if.carry_out), 32'(0));
    check("rmid alu_cmd", 32'(bus_if.alu_cmd), 32'(3'b111));
    check("rmid alu_sc_in", 32'(bus_if.alu_sc_in), 32'(0));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.done || bus_if.busy) pulses++;
      @(posedge clk); #1;
    end
    check("rmid no_done", 32'(pulses), 32'(0));

    // 6: rotate request (honoured only with the optional feature)
`ifdef SHIFT_ROTATE_EN
    run_op("rotl4", 1'b0, 1'b0, 1'b1, 4'd4, 16'h8001, 16'h0018, 1'b0);
    check("rotl4 ts0", 32'(ts_log[0]), 32'(3'b001));
    run_op("rotr1", 1'b1, 1'b0, 1'b1, 4'd1, 16'h0001, 16'h8000, 1'b1);
`else
    run_op("rotl4", 1'b0, 1'b0, 1'b1, 4'd4, 16'h8001, 16'h0010, 1'b0);
    check("rotl4 ts0", 32'(ts_log[0]), 32'(3'b000));
    run_op("rotr1", 1'b1, 1'b0, 1'b1, 4'd1, 16'h0001, 16'h0000, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
